// File: rtl/prog_loader.sv
// Program loader: assembles big-endian byte pairs from a byte stream into
// instruction words and writes them into program memory, holding the CPU
// core in reset for the duration of the load.
`timescale 1ns/1ps
module prog_loader #(
  parameter int PC_WIDTH  = 8,
  parameter int DataWidth = 16,
  parameter int CMD_CNT   = 64
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  load_len,
  input  logic                 abort,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [PC_WIDTH-1:0]  mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_hold_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    len_q, len_nxt;
  logic [PC_WIDTH-1:0]    addr_q, addr_nxt;
  logic [DataWidth-1:0]   wdata_q, wdata_nxt;
  logic                   handshake;

  // Requested length limited to the program-memory capacity of one load.
  function automatic logic [PC_WIDTH-1:0] clamp_len(input logic [PC_WIDTH-1:0] req);
    if (32'(req) > CMD_CNT) return PC_WIDTH'(CMD_CNT);
    return req;
  endfunction

  assign handshake = byte_valid && byte_ready;

  // Outputs are decoded from the registered state and datapath only.
  assign byte_ready = (state == S_HI) || (state == S_LO);
  assign mem_we     = (state == S_WRITE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign cpu_hold_n = (state == S_IDLE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  // State and datapath registers; reset returns everything to a clean idle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      len_q   <= len_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  // Next-state and datapath update; abort always wins over a byte transfer.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          len_nxt   = clamp_len(load_len);
          addr_nxt  = '0;
          state_nxt = (clamp_len(load_len) == '0) ? S_DONE : S_HI;
        end
      end
      S_HI: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (handshake) begin
          wdata_nxt[DataWidth-1 -: 8] = byte_data;
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (handshake) begin
          wdata_nxt[7:0] = byte_data;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write itself happens this cycle regardless of abort.
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (addr_q == (len_q - PC_ONE)) begin
          state_nxt = S_DONE;
        end else begin
          addr_nxt  = addr_q + PC_ONE;
          state_nxt = S_HI;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-memory address width.
REQ-002 SHALL have parameter DataWidth, default 16, instruction word width; fixed at two bytes.
REQ-003 SHALL have parameter CMD_CNT, default 64, maximum number of words per load.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port res_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request to begin a load; sampled only in IDLE.
REQ-007 SHALL have port load_len  input  PC_WIDTH  number of words to load; sampled with start.
REQ-008 SHALL have port abort  input  1  terminate the load in progress.
REQ-009 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-010 SHALL have port byte_data  input  8  incoming program byte, high byte of each word first.
REQ-011 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-012 SHALL have port mem_we  output  1  program-memory write strobe.
REQ-013 SHALL have port mem_addr  output  PC_WIDTH  program-memory write address.
REQ-014 SHALL have port mem_wdata  output  DataWidth  instruction word to write.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  single-cycle pulse on normal load completion.
REQ-017 SHALL have port cpu_hold_n  output  1  low while loading; holds the CPU core in reset.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, HI, LO, WRITE, DONE; all outputs decoded from registered state and datapath registers.
REQ-019 SHALL transfer a byte only when byte_valid and byte_ready are both high at a rising edge.
REQ-020 SHALL drive byte_ready high only in HI and LO.
REQ-021 IDLE: on start, latch len = min(load_len, CMD_CNT), clear address to 0; go to DONE if len = 0, otherwise to HI.
REQ-022 HI: on a handshake, store byte_data in wdata[15:8] and go to LO; otherwise stay.
REQ-023 LO: on a handshake, store byte_data in wdata[7:0] and go to WRITE; otherwise stay.
REQ-024 WRITE: hold mem_we high for exactly one cycle with the current mem_addr and mem_wdata.
REQ-025 On leaving WRITE, go to DONE if mem_addr = len-1; otherwise increment mem_addr by 1 and go to HI.
REQ-026 DONE: hold done high for exactly one cycle, then go to IDLE.
REQ-027 Timing: the write cycle SHALL be the cycle immediately after the low-byte handshake edge; minimum 3 cycles per word.
REQ-028 Outside WRITE, mem_we SHALL be 0; mem_addr and mem_wdata hold their last values.
REQ-029 start SHALL be ignored in all states other than IDLE.
REQ-030 Abort in HI, LO or DONE: go to IDLE at the next edge; no further write; no done pulse.
REQ-031 Abort in WRITE: the write in that cycle still completes; the next state is IDLE with no done pulse.
REQ-032 When abort and a byte handshake coincide, abort has priority and the byte is discarded.
REQ-033 cpu_hold_n SHALL be 0 in HI, LO, WRITE and DONE, and 1 in IDLE.
REQ-034 Address SHALL never exceed CMD_CNT-1; no wrap-around within one load.

Reset
REQ-035 While res_n is low, SHALL immediately go to IDLE with byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold_n=1.
REQ-036 Reset asserted mid-load SHALL abandon the load at once; no write or done pulse follows release.
REQ-037 After res_n rises, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Verification
REQ-038 Load two words: start with load_len=2, then bytes 0x49,0x03,0x4A,0x14 with no gaps -> writes 0x4903 at address 0, then 0x4A14 at address 1; one done pulse; busy is high for the whole load.
REQ-039 Same load with byte_valid low for 3 cycles between every byte -> identical writes; mem_we never high outside WRITE.
REQ-040 start with load_len=0 -> DONE on the next cycle, then IDLE; done pulses once; mem_we stays 0.
REQ-041 start with load_len=100 -> clamped to 64; last write at address 63; done follows the 64th write.
REQ-042 abort raised in LO after high byte 0x80 is accepted -> state goes to IDLE; no write; no done; cpu_hold_n returns to 1.
REQ-043 res_n pulled low while in HI during the second word -> all outputs take their reset values immediately; no activity after release until the next start.
